// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller: scan FSM states and
// the active-low seven-segment font table.
package fnd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GUARD,
      SHOW
   } state_t;

   localparam logic [7:0] FONT_OFF = 8'hFF;

   // Index is the hex nibble; bit7 (dp) is kept high so the table alone means "dp off".
   localparam logic [7:0] FONT_LUT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

endpackage

// File: rtl/fnd_scan_ctrl_font_dec.sv
// Combinational nibble/dp/blank to active-low {dp,g,f,e,d,c,b,a} font.
module fnd_font_dec
   import fnd_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] font
);

   logic [7:0] lut_font;

   assign lut_font = FONT_LUT[nibble];
   assign font     = {~dp, blank ? 7'h7F : lut_font[6:0]};

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with guard interval and a
// double-buffered display image that commits only at frame boundaries.
module fnd_scan_ctrl
   import fnd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int GUARD_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_enable,
   input  logic                    i_wr_valid,
   output logic                    o_wr_ready,
   input  logic [4*NUM_DIGITS-1:0] i_wr_data,
   input  logic [NUM_DIGITS-1:0]   i_wr_dp,
   input  logic                    i_lz_blank,
   output logic [NUM_DIGITS-1:0]   o_fnd_com,
   output logic [7:0]              o_fnd_font,
   output logic                    o_frame_done
);

   localparam int MAX_CYC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW      = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam state_t           AFTER_IDLE = (GUARD_CYC == 0) ? SHOW : GUARD;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic                  boundary;

   logic [DW-1:0]         shadow_data, shadow_data_nxt;
   logic [NUM_DIGITS-1:0] shadow_dp, shadow_dp_nxt;
   logic [DW-1:0]         act_data, act_data_nxt;
   logic [NUM_DIGITS-1:0] act_dp, act_dp_nxt;
   logic                  pending, pending_nxt;
   logic                  commit, accept;

   logic [NUM_DIGITS-1:0] blank_mask;
   logic                  lead;
   logic [3:0]            cur_nibble;
   logic [7:0]            dec_font;
   logic [NUM_DIGITS-1:0] com_nxt;
   logic [7:0]            font_nxt;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      boundary  = 1'b0;
      if (!i_enable) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         idx_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = AFTER_IDLE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
            GUARD: begin
               if (cnt == GUARD_LAST) begin
                  state_nxt = SHOW;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            SHOW: begin
               if (cnt == SCAN_LAST) begin
                  state_nxt = AFTER_IDLE;
                  cnt_nxt   = '0;
                  if (idx == IDX_LAST) begin
                     idx_nxt  = '0;
                     boundary = 1'b1;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   // Commit and accept are mutually exclusive: one needs pending set, the other clear.
   always_comb begin
      commit          = pending && (boundary || (state == IDLE));
      accept          = i_wr_valid && !pending;
      pending_nxt     = pending;
      shadow_data_nxt = shadow_data;
      shadow_dp_nxt   = shadow_dp;
      act_data_nxt    = act_data;
      act_dp_nxt      = act_dp;
      if (commit) begin
         act_data_nxt = shadow_data;
         act_dp_nxt   = shadow_dp;
         pending_nxt  = 1'b0;
      end
      if (accept) begin
         shadow_data_nxt = i_wr_data;
         shadow_dp_nxt   = i_wr_dp;
         pending_nxt     = 1'b1;
      end
   end

   // Blank zero digits from the MSB down until the first nonzero; digit0 always shows.
   always_comb begin
      blank_mask = '0;
      lead       = i_lz_blank;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (lead && (act_data_nxt[4*i +: 4] == 4'h0)) begin
            blank_mask[i] = 1'b1;
         end else begin
            lead = 1'b0;
         end
      end
   end

   assign cur_nibble = act_data_nxt[{idx_nxt, 2'b00} +: 4];

   fnd_font_dec u_font_dec (
      .nibble (cur_nibble),
      .dp     (act_dp_nxt[idx_nxt]),
      .blank  (blank_mask[idx_nxt]),
      .font   (dec_font)
   );

   always_comb begin
      com_nxt  = '1;
      font_nxt = FONT_OFF;
      if (state_nxt == SHOW) begin
         com_nxt[idx_nxt] = 1'b0;
         font_nxt         = dec_font;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         // NOTE: the display buffers are reset because a cleared image is part of the defined reset state.
         shadow_data  <= '0;
         shadow_dp    <= '0;
         act_data     <= '0;
         act_dp       <= '0;
         pending      <= 1'b0;
         o_wr_ready   <= 1'b1;
         o_fnd_com    <= '1;
         o_fnd_font   <= FONT_OFF;
         o_frame_done <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         shadow_data  <= shadow_data_nxt;
         shadow_dp    <= shadow_dp_nxt;
         act_data     <= act_data_nxt;
         act_dp       <= act_dp_nxt;
         pending      <= pending_nxt;
         o_wr_ready   <= !pending_nxt;
         o_fnd_com    <= com_nxt;
         o_fnd_font   <= font_nxt;
         o_frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: a position-in-frame reference model
// queues expected outputs each edge; a negedge monitor pops and compares.
module tb_fnd_scan_ctrl;

   localparam int N     = 4;
   localparam int SD    = 4;
   localparam int GC    = 2;
   localparam int P     = SD + GC;
   localparam int FRAME = N * P;

   localparam logic [7:0] SEG [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic          clk = 1'b0;
   logic          reset;
   logic          i_enable;
   logic          i_wr_valid;
   logic          o_wr_ready;
   logic [15:0]   i_wr_data;
   logic [3:0]    i_wr_dp;
   logic          i_lz_blank;
   logic [3:0]    o_fnd_com;
   logic [7:0]    o_fnd_font;
   logic          o_frame_done;

   always #5 clk = ~clk;

   fnd_scan_ctrl #(
      .NUM_DIGITS (N),
      .SCAN_DIV   (SD),
      .GUARD_CYC  (GC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_enable     (i_enable),
      .i_wr_valid   (i_wr_valid),
      .o_wr_ready   (o_wr_ready),
      .i_wr_data    (i_wr_data),
      .i_wr_dp      (i_wr_dp),
      .i_lz_blank   (i_lz_blank),
      .o_fnd_com    (o_fnd_com),
      .o_fnd_font   (o_fnd_font),
      .o_frame_done (o_frame_done)
   );

   typedef struct packed {
      logic [3:0] com;
      logic [7:0] font;
      logic       ready;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   // Reference model: scanning is described only by the cycle position since enable.
   bit          m_run  = 1'b0;
   int          m_pos  = 0;
   bit          m_pend = 1'b0;
   logic [15:0] m_sh_d = '0, m_act_d = '0;
   logic [3:0]  m_sh_dp = '0, m_act_dp = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic logic [7:0] exp_font(input int d);
      logic [15:0] upper;
      logic [7:0]  s;
      bit          blank;
      upper = m_act_d >> (4 * d);
      s     = SEG[upper[3:0]];
      blank = i_lz_blank && (d > 0) && (upper == 16'h0);
      return {~m_act_dp[d], blank ? 7'h7F : s[6:0]};
   endfunction

   task automatic model_edge();
      exp_t e;
      bit   was_run, old_pend, bnd, commit, accept;
      int   d;
      if (reset) begin
         m_run = 0; m_pos = 0; m_pend = 0;
         m_sh_d = '0; m_sh_dp = '0; m_act_d = '0; m_act_dp = '0;
         e = '{com: 4'hF, font: 8'hFF, ready: 1'b1, done: 1'b0};
      end else begin
         was_run  = m_run;
         old_pend = m_pend;
         if (i_enable) begin
            m_pos = was_run ? m_pos + 1 : 0;
            m_run = 1;
         end else begin
            m_pos = 0;
            m_run = 0;
         end
         bnd    = m_run && was_run && (m_pos % FRAME == 0);
         commit = old_pend && (!was_run || bnd);
         accept = i_wr_valid && !old_pend;
         if (commit) begin
            m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_pend = 0;
         end
         if (accept) begin
            m_sh_d = i_wr_data; m_sh_dp = i_wr_dp; m_pend = 1;
         end
         e.done  = bnd;
         e.ready = !m_pend;
         if (m_run && (m_pos % P) >= GC) begin
            d      = (m_pos / P) % N;
            e.com  = ~(4'b0001 << d);
            e.font = exp_font(d);
         end else begin
            e.com  = 4'hF;
            e.font = 8'hFF;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic write_img(input logic [15:0] data, input logic [3:0] dp);
      int k = 0;
      i_wr_valid = 1'b0;
      while (m_pend && k < 4 * FRAME) begin
         tick();
         k++;
      end
      i_wr_valid = 1'b1;
      i_wr_data  = data;
      i_wr_dp    = dp;
      tick();
      i_wr_valid = 1'b0;
   endtask

   task automatic wait_pos(input int target);
      int k = 0;
      while (!(m_run && (m_pos % FRAME) == target) && k < 2 * FRAME) begin
         tick();
         k++;
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("fnd_com", 32'(o_fnd_com), 32'(mon_e.com));
         check("fnd_font", 32'(o_fnd_font), 32'(mon_e.font));
         check("wr_ready", 32'(o_wr_ready), 32'(mon_e.ready));
         check("frame_done", 32'(o_frame_done), 32'(mon_e.done));
      end
   end

   initial begin
      logic [15:0] rd;
      int          k;
      reset = 1'b1; i_enable = 1'b0; i_wr_valid = 1'b0;
      i_wr_data = '0; i_wr_dp = '0; i_lz_blank = 1'b0;
      run(3);
      reset = 1'b0;
      run(2);

      // Image written while idle, then two full frames.
      write_img(16'h1234, 4'b0000);
      run(2);
      i_enable = 1'b1;
      run(2 * FRAME);

      // Mid-frame write, followed by a stalled second write.
      wait_pos(10);
      i_wr_valid = 1'b1; i_wr_data = 16'h5678; i_wr_dp = 4'b0001;
      tick();
      i_wr_data = 16'h9999; i_wr_dp = 4'b1111;
      run(5);
      i_wr_valid = 1'b0;
      run(2 * FRAME);

      // Leading-zero blanking on and off.
      write_img(16'h0050, 4'b0000);
      i_lz_blank = 1'b1;
      run(2 * FRAME);
      i_lz_blank = 1'b0;
      run(FRAME);

      // Enable dropped during digit2, then resumed.
      wait_pos(2 * P + GC + 1);
      i_enable = 1'b0;
      run(3);
      i_enable = 1'b1;
      run(FRAME + 4);

      // Reset mid-SHOW with a write pending.
      wait_pos(GC + 1);
      write_img(16'h1357, 4'b1010);
      run(1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      run(FRAME + 2);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         reset      = ($urandom_range(0, 499) == 0);
         i_enable   = ($urandom_range(0, 59) != 0);
         i_wr_valid = ($urandom_range(0, 9) == 0);
         rd = 16'($urandom);
         for (int n = 0; n < N; n++)
            if ($urandom_range(0, 1) == 0) rd[4*n +: 4] = 4'h0;
         i_wr_data = rd;
         i_wr_dp   = 4'($urandom);
         if ($urandom_range(0, 99) == 0) i_lz_blank = ~i_lz_blank;
         tick();
      end
      reset = 1'b0; i_wr_valid = 1'b0;

      k = 0;
      while (exp_q.size() > 0 && k < 10) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
- Time-multiplexed 7-segment (FND) display controller.
- Owns the digit-select sequencing: prescaled scan tick, a mod-NUM_DIGITS digit index, and an anti-ghosting guard interval between digits.
- Holds a double-buffered display image: writes land in a shadow buffer and commit only at frame boundaries, so a digit update never tears mid-frame.
- Sits between the application logic (clock/stopwatch values) and the board FND pins.

Parameters:
- NUM_DIGITS, 4: digits scanned, legal 1..8.
- SCAN_DIV, 100000: cycles each digit is lit, legal >=1 (1 ms at 100 MHz).
- GUARD_CYC, 16: all-off cycles before each digit, legal >=0; 0 removes the GUARD state.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_enable  in  1  scan enable; low forces display off
- i_wr_valid  in  1  write request for a new display image
- o_wr_ready  out  1  shadow buffer empty; write accepted when valid&&ready
- i_wr_data  in  4*NUM_DIGITS  hex nibbles, digit0 in [3:0]
- i_wr_dp  in  NUM_DIGITS  decimal-point enables, written with i_wr_data
- i_lz_blank  in  1  leading-zero blanking enable (live, not buffered)
- o_fnd_com  out  NUM_DIGITS  digit enables, active-low
- o_fnd_font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- o_frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, idx=0, cycle counter=0.
  - Active and shadow buffers cleared; pending=0.
  - o_fnd_com all 1, o_fnd_font=8'hFF, o_wr_ready=1, o_frame_done=0.
- All outputs are registered and update on the same edge as the state register.
- States: IDLE, GUARD, SHOW.
  - IDLE: display off, idx=0. If i_enable=1, next state is GUARD (or SHOW when GUARD_CYC=0).
  - GUARD: o_fnd_com all 1, font 8'hFF, for exactly GUARD_CYC cycles, then SHOW.
  - SHOW: o_fnd_com[idx]=0 (others 1), font=decode(idx), for exactly SCAN_DIV cycles. Then idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1, and next state is GUARD.
- Period per digit is GUARD_CYC+SCAN_DIV cycles; frame is NUM_DIGITS times that.
- i_enable=0 in any state: next cycle is IDLE with outputs off and idx=0. Pending data is kept.
- Frame boundary is the SHOW exit with idx==NUM_DIGITS-1. On that cycle:
  - o_frame_done=1 for one cycle.
  - If pending, active <= shadow and pending <= 0.
- In IDLE, pending commits on the cycle after acceptance.
- o_wr_ready = !pending.
  - A write accepted on the commit cycle (pending was empty) becomes pending and commits at the next boundary.
  - While pending, further writes stall; there is no overwrite.
- Decode (active-low gfedcba): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - dp bit7 is driven 0 when the active dp bit for that digit is set.
- Leading-zero blanking (i_lz_blank=1): digits from MSB downward whose nibble is 0 are blanked, stopping at the first nonzero digit.
  - Digit0 is never blanked.
  - A blanked digit shows segments 7'h7F; its dp is still honoured.
  - o_fnd_com still pulses for blanked digits, so brightness timing stays unchanged.
- Counters are $clog2-sized and wrap with no overflow past terminal values.
- Reset mid-operation aborts the current digit and returns everything to reset values on the next edge.

Decomposition:
- Package fnd_pkg:
  - state enum (IDLE/GUARD/SHOW).
  - 16-entry font constant array.
  - FONT_OFF=8'hFF.
- Sub-module fnd_font_dec: combinational nibble+dp+blank -> 8-bit font.
- The rest (FSM, scan/guard counter, idx counter, buffers, blanking mask) lives in fnd_scan_ctrl.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYC=2):
1. Reset 3 cycles, i_enable=0 -> com=4'b1111, font=8'hFF, wr_ready=1, frame_done=0 throughout.
2. Write 16'h1234 in IDLE, then enable=1:
   - com sequence: 1111 for 2 cycles, 1110 for 4, 1111 for 2, 1101 for 4, 1011, 0111.
   - Fonts while lit: 99, B0, A4, F9.
   - frame_done pulses every 24 cycles.
3. Mid-frame write 16'h5678 (dp=4'b0001):
   - Display stays 1234 until the boundary; wr_ready=0 from the accept cycle.
   - A second write is stalled.
   - After frame_done, fonts are 80 with dp low (digit0 = 8'h00), F8, 82, 92; wr_ready=1.
4. Data 16'h0050, lz=1 -> digit3/digit2 fonts FF with com still pulsing, digit1=92, digit0=C0. With lz=0, digits 3/2 show C0.
5. Drop i_enable mid-SHOW of digit2 -> next cycle com=1111, font=FF; on re-enable, scanning restarts at digit0 after GUARD.
6. Assert reset mid-SHOW with a write pending -> next cycle all outputs at reset values, wr_ready=1; after enable, all digits show C0.
